// File: rtl/canbus_bit_timing.sv
// ---------------------------------------------------------------------------
// canbus_bit_timing
//
// Bit-timing front end for the CAN receive/transmit pair. The raw rx pin is
// synchronised, each nominal bit is split into time quanta
// (SYNC / TSEG1 / TSEG2), and the local bit clock is hard- or soft-synced to
// recessive->dominant transitions. Instead of divided clocks, the block emits
// single-cycle strobes in the clk domain.
//
// Parameters
//   TQ_DIV     clk cycles per time quantum (>= 2)
//   TSEG1      quanta from end of SYNC to the sample point (>= 2)
//   TSEG2      quanta from the sample point to end of bit (>= SJW, >= 1)
//   SJW        maximum soft-resync adjustment in quanta (1..4)
//   IDLE_BITS  consecutive recessive samples that declare the bus idle
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   rx          raw CAN rx pin, asynchronous to clk
//   rx_bit      bit value captured at the most recent sample point
//   sample_stb  1-clk pulse, rx_bit updated in this cycle
//   tx_stb      1-clk pulse at start of SYNC: transmitter drives next bit now
//   bus_idle    high after IDLE_BITS recessive samples, low on a dominant one
//   resync_cnt  wrapping count of soft resyncs performed (debug)
// ---------------------------------------------------------------------------
module canbus_bit_timing #(
    parameter int unsigned TQ_DIV    = 12,
    parameter int unsigned TSEG1     = 6,
    parameter int unsigned TSEG2     = 2,
    parameter int unsigned SJW       = 1,
    parameter int unsigned IDLE_BITS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_bit,
    output logic       sample_stb,
    output logic       tx_stb,
    output logic       bus_idle,
    output logic [7:0] resync_cnt
);

    localparam int unsigned TQW = $clog2(TQ_DIV);
    localparam int unsigned IW  = $clog2(IDLE_BITS + 1);

    localparam logic [TQW-1:0] TQ_LAST = TQW'(TQ_DIV - 1);
    localparam logic [7:0]     TSEG1_L = 8'(TSEG1);
    localparam logic [7:0]     TSEG2_L = 8'(TSEG2);
    localparam logic [7:0]     SJW_L   = 8'(SJW);
    localparam logic [IW-1:0]  IDLE_L  = IW'(IDLE_BITS);

    typedef enum logic [1:0] {
        SEG_SYNC,
        SEG_TSEG1,
        SEG_TSEG2
    } seg_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    seg_t           seg;
    seg_t           seg_nxt;
    logic [TQW-1:0] tq_cnt;
    logic [TQW-1:0] tq_nxt;
    logic [7:0]     qn;
    logic [7:0]     qn_nxt;
    logic [7:0]     seg_len;
    logic [7:0]     len_nxt;
    logic           resync_done;
    logic           rd_nxt;

    logic           sync1;
    logic           rx_s;
    logic           rx_q;
    logic [IW-1:0]  idle_cnt;

    logic           tq_tick;
    logic           rx_edge;
    logic           hard_sync;
    logic           soft_sync;
    logic [7:0]     late_e;
    logic [7:0]     late_adj;
    logic [7:0]     early_e;

    logic           sample_evt;
    logic           tx_evt;

    // ------------------------------------------------------------------
    // rx synchroniser: two flops to rx_s, plus one history flop for edges.
    // Reset to recessive so release never fakes a falling edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Edge classification
    // ------------------------------------------------------------------
    always_comb begin
        tq_tick   = (tq_cnt == TQ_LAST);
        // Only recessive->dominant counts, and only if the last sampled bit
        // was recessive; this filters glitches inside a dominant bit.
        rx_edge   = rx_q & ~rx_s & rx_bit;
        hard_sync = rx_edge & bus_idle;
        soft_sync = rx_edge & ~bus_idle & ~resync_done & (seg != SEG_SYNC);
        // Phase error in quanta for a late edge (in TSEG1) and an early
        // edge (in TSEG2).
        late_e    = qn + 8'd1;
        late_adj  = (late_e < SJW_L) ? late_e : SJW_L;
        early_e   = TSEG2_L - qn;
    end

    // ------------------------------------------------------------------
    // Segment FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_SYNC;
            tq_cnt      <= '0;
            qn          <= '0;
            seg_len     <= TSEG1_L;
            resync_done <= 1'b0;
        end else begin
            seg         <= seg_nxt;
            tq_cnt      <= tq_nxt;
            qn          <= qn_nxt;
            seg_len     <= len_nxt;
            resync_done <= rd_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Segment FSM: next state
    //
    // Sync handling is resolved first; the quantum boundary is then
    // evaluated against the possibly adjusted segment length, so an edge
    // arriving on the same clk as tq_tick takes effect before the tick.
    // ------------------------------------------------------------------
    always_comb begin
        seg_nxt = seg;
        tq_nxt  = tq_tick ? '0 : tq_cnt + 1'b1;
        qn_nxt  = qn;
        len_nxt = seg_len;
        rd_nxt  = resync_done;

        if (hard_sync) begin
            // Restart the bit at SYNC; the edge itself is the SYNC quantum.
            tq_nxt  = '0;
            seg_nxt = SEG_SYNC;
            qn_nxt  = '0;
            len_nxt = TSEG1_L;
            rd_nxt  = 1'b1;
        end else if (soft_sync && (seg == SEG_TSEG2) && (early_e <= SJW_L)) begin
            // Early edge within SJW: finish TSEG2 immediately and begin the
            // next bit here.
            tq_nxt  = '0;
            seg_nxt = SEG_SYNC;
            qn_nxt  = '0;
            len_nxt = TSEG1_L;
            rd_nxt  = 1'b1;
        end else begin
            if (soft_sync) begin
                rd_nxt = 1'b1;
                if (seg == SEG_TSEG1) begin
                    len_nxt = seg_len + late_adj;
                end else begin
                    len_nxt = seg_len - SJW_L;
                end
            end

            if (tq_tick) begin
                unique case (seg)
                    SEG_SYNC: begin
                        seg_nxt = SEG_TSEG1;
                        qn_nxt  = '0;
                    end
                    SEG_TSEG1: begin
                        if (qn == len_nxt - 8'd1) begin
                            seg_nxt = SEG_TSEG2;
                            qn_nxt  = '0;
                            len_nxt = TSEG2_L;
                        end else begin
                            qn_nxt = qn + 8'd1;
                        end
                    end
                    SEG_TSEG2: begin
                        if (qn == len_nxt - 8'd1) begin
                            seg_nxt = SEG_SYNC;
                            qn_nxt  = '0;
                            len_nxt = TSEG1_L;
                            rd_nxt  = 1'b0;
                        end else begin
                            qn_nxt = qn + 8'd1;
                        end
                    end
                    default: begin
                        seg_nxt = SEG_SYNC;
                        qn_nxt  = '0;
                        len_nxt = TSEG1_L;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment FSM: output decode from the transition being taken.
    // A hard sync lands in SYNC without announcing a new transmit bit.
    // ------------------------------------------------------------------
    always_comb begin
        sample_evt = (seg == SEG_TSEG1) && (seg_nxt == SEG_TSEG2);
        tx_evt     = (seg != SEG_SYNC) && (seg_nxt == SEG_SYNC) && !hard_sync;
    end

    // ------------------------------------------------------------------
    // Registered outputs, sampled bit and idle detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_bit     <= 1'b1;
            sample_stb <= 1'b0;
            tx_stb     <= 1'b0;
            bus_idle   <= 1'b0;
            resync_cnt <= '0;
            idle_cnt   <= '0;
        end else begin
            sample_stb <= sample_evt;
            tx_stb     <= tx_evt;

            if (soft_sync) begin
                resync_cnt <= resync_cnt + 8'd1;
            end

            if (sample_evt) begin
                rx_bit <= rx_s;
                if (rx_s) begin
                    if (idle_cnt != IDLE_L) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    if (idle_cnt >= IDLE_L - 1'b1) begin
                        bus_idle <= 1'b1;
                    end
                end else begin
                    idle_cnt <= '0;
                    bus_idle <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_canbus_bit_timing.sv
// ---------------------------------------------------------------------------
// tb_canbus_bit_timing
//
// Directed bench for canbus_bit_timing at default parameters
// (12 clk/tq, TSEG1=6, TSEG2=2, SJW=1, IDLE_BITS=11).
// cyc counts posedges; all outputs are looked at on the falling edge, so a
// strobe registered at posedge N is seen with cyc == N.
// An rx change driven at the negedge where cyc == N-3 reaches the edge
// detector in time to be acted on at posedge N (two sync flops + history).
// ---------------------------------------------------------------------------
module tb_canbus_bit_timing;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_bit;
    logic       sample_stb;
    logic       tx_stb;
    logic       bus_idle;
    logic [7:0] resync_cnt;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    canbus_bit_timing #(
        .TQ_DIV   (12),
        .TSEG1    (6),
        .TSEG2    (2),
        .SJW      (1),
        .IDLE_BITS(11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_bit    (rx_bit),
        .sample_stb(sample_stb),
        .tx_stb    (tx_stb),
        .bus_idle  (bus_idle),
        .resync_cnt(resync_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_cyc(input int e);
        if (cyc > e) check("schedule", cyc, e);
        while (cyc < e) @(negedge clk);
    endtask

    // Drive rx so the resulting edge is acted on at posedge x.
    task automatic act_at(input int x, input logic v);
        wait_cyc(x - 3);
        rx = v;
    endtask

    task automatic wait_tx(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_stb && n < 400);
        check("tx_seen", int'(tx_stb), 1);
        t = cyc;
    endtask

    task automatic wait_smp(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_stb && n < 400);
        check("smp_seen", int'(sample_stb), 1);
        t = cyc;
    endtask

    initial begin
        int c0, t, s11, h, tb1, tb2, tb3, tb4, tb5, tb6, tb7, tb8, tb9;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rx_bit", int'(rx_bit), 1);
        check("rst_sample_stb", int'(sample_stb), 0);
        check("rst_tx_stb", int'(tx_stb), 0);
        check("rst_bus_idle", int'(bus_idle), 0);
        check("rst_resync_cnt", int'(resync_cnt), 0);

        // 1: recessive bus, 11 bits; first sample 84 clks after release,
        //    then every 108; bus_idle rises on the 11th sample.
        c0    = cyc;
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            wait_smp(t);
            check("t1_smp_time", t, c0 + 84 + 108 * (i - 1));
            check("t1_rx_bit", int'(rx_bit), 1);
            check("t1_bus_idle", int'(bus_idle), (i == 11) ? 1 : 0);
        end
        s11 = t;
        check("t1_resync_cnt", int'(resync_cnt), 0);

        // 2: hard sync on an idle bus at an arbitrary phase. Edge acted on
        //    3 clks after the drive, sample 84 clks after that.
        wait_cyc(s11 + 37);
        rx = 1'b0;
        h  = s11 + 40;
        wait_smp(t);
        check("t2_smp_time", t, h + 84);
        check("t2_rx_bit", int'(rx_bit), 0);
        check("t2_bus_idle", int'(bus_idle), 0);
        check("t2_resync_cnt", int'(resync_cnt), 0);

        // 3: recessive bit, then a falling edge 2 tq into TSEG1 (qn=1)
        //    of the following bit: TSEG1 grows by SJW -> 120-clk bit.
        rx = 1'b1;
        wait_tx(tb1);
        check("t3_tx_after_hard", tb1, h + 108);
        wait_smp(t);
        check("t3_rec_rx_bit", int'(rx_bit), 1);
        wait_tx(tb2);
        check("t3_rec_len", tb2 - tb1, 108);
        act_at(tb2 + 30, 1'b0);
        wait_smp(t);
        check("t3_late_smp", t - tb2, 96);
        check("t3_late_rx_bit", int'(rx_bit), 0);
        wait_tx(tb3);
        check("t3_late_len", tb3 - tb2, 120);
        check("t3_resync_cnt", int'(resync_cnt), 1);

        // 4a: edge exactly one tq before the end of TSEG2, on the same clk
        //     as the quantum tick: TSEG2 shrinks to 1 tq -> 96-clk bit.
        rx = 1'b1;
        wait_smp(t);
        check("t4_rec_rx_bit", int'(rx_bit), 1);
        act_at(tb3 + 96, 1'b0);
        wait_tx(tb4);
        check("t4_early_len", tb4 - tb3, 96);
        check("t4_resync_cnt", int'(resync_cnt), 2);

        // 4b: edge one clk into the last TSEG2 quantum: e=1 <= SJW, so the
        //     bit ends at that edge (97 clks) with tx_stb there.
        wait_smp(t);
        check("t4_dom_rx_bit", int'(rx_bit), 0);
        rx = 1'b1;
        wait_tx(tb5);
        check("t4_dom_len", tb5 - tb4, 108);
        wait_smp(t);
        check("t4b_rec_rx_bit", int'(rx_bit), 1);
        act_at(tb5 + 97, 1'b0);
        wait_tx(tb6);
        check("t4b_early_len", tb6 - tb5, 97);
        check("t4b_resync_cnt", int'(resync_cnt), 3);

        // Dominant bit, then a recessive one; both nominal length.
        wait_smp(t);
        check("t4b_dom_rx_bit", int'(rx_bit), 0);
        rx = 1'b1;
        wait_tx(tb7);
        check("t4b_next_len", tb7 - tb6, 108);
        wait_smp(t);
        check("t5_pre_rx_bit", int'(rx_bit), 1);
        wait_tx(tb8);
        check("t5_pre_len", tb8 - tb7, 108);

        // 5: late fall, rise, second fall all in one TSEG1: one adjustment.
        act_at(tb8 + 30, 1'b0);
        act_at(tb8 + 42, 1'b1);
        act_at(tb8 + 52, 1'b0);
        wait_smp(t);
        check("t5_smp", t - tb8, 96);
        check("t5_rx_bit", int'(rx_bit), 0);
        wait_tx(tb9);
        check("t5_len", tb9 - tb8, 120);
        check("t5_resync_cnt", int'(resync_cnt), 4);

        //    Rise then fall while the last sampled bit is dominant: no resync.
        act_at(tb9 + 12, 1'b1);
        act_at(tb9 + 40, 1'b0);
        wait_smp(t);
        check("t5_dom_smp", t - tb9, 84);
        check("t5_dom_rx_bit", int'(rx_bit), 0);
        wait_tx(tb1);
        check("t5_dom_len", tb1 - tb9, 108);
        check("t5_dom_resync_cnt", int'(resync_cnt), 4);

        // 6: reset for 5 clks mid-TSEG1; outputs clear at once, timing
        //    restarts from SYNC on release.
        rx = 1'b1;
        wait_cyc(tb1 + 40);
        rst_n = 1'b0;
        #1;
        check("t6_rx_bit", int'(rx_bit), 1);
        check("t6_sample_stb", int'(sample_stb), 0);
        check("t6_tx_stb", int'(tx_stb), 0);
        check("t6_bus_idle", int'(bus_idle), 0);
        check("t6_resync_cnt", int'(resync_cnt), 0);
        repeat (5) @(negedge clk);
        c0    = cyc;
        rst_n = 1'b1;
        wait_smp(t);
        check("t6_first_smp", t - c0, 84);
        check("t6_smp_rx_bit", int'(rx_bit), 1);
        check("t6_smp_bus_idle", int'(bus_idle), 0);
        wait_tx(t);
        check("t6_first_tx", t - c0, 108);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
